// File: rtl/cart_ram_backup.sv
// cart_ram_backup: battery-save engine moving cartridge RAM
// to/from the SD sector buffer in 512-byte blocks.
module cart_ram_backup (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [7:0]  cart_mbc_type,
   input  logic [7:0]  cart_ram_size,
   input  logic        load_req,
   input  logic        save_req,
   input  logic        autosave_en,
   input  logic        osd_open,
   input  logic        cart_ram_wr,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        sav_pending,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   input  logic [8:0]  sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   input  logic        sd_buff_wr,
   output logic [7:0]  sd_buff_din,
   output logic [16:0] bk_addr,
   output logic        bk_wr,
   output logic [7:0]  bk_din,
   input  logic [7:0]  bk_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_XFER,
      S_NEXT,
      S_DONE
   } state_t;

   state_t     state;
   state_t     state_d;

   logic       load_r, load_p;
   logic       save_r, save_p;
   logic       osd_r, osd_p;
   logic       ack_q;
   logic       loading;
   logic [7:0] lba;

   logic       is_battery;
   logic       is_mbc2;
   logic       size_ok;
   logic       cart_ok;
   logic [7:0] last_lba;

   logic       load_rise;
   logic       save_rise;
   logic       auto_go;
   logic       accept;
   logic       reject;
   logic       ack_rise;
   logic       ack_fall;
   logic       at_last;

   // Decode cartridge header: battery presence, MBC2, last block.
   always_comb begin
      is_battery = 1'b0;
      case (cart_mbc_type)
         8'h03, 8'h06, 8'h09, 8'h0D, 8'h10,
         8'h13, 8'h1B, 8'h1E, 8'h22, 8'hFF:
            is_battery = 1'b1;
         default: is_battery = 1'b0;
      endcase
      is_mbc2 = (cart_mbc_type == 8'h05) ||
                (cart_mbc_type == 8'h06);
      size_ok = is_mbc2 || (cart_ram_size != 8'd0);
      cart_ok = is_battery && size_ok;
      last_lba = 8'd0;
      if (!is_mbc2) begin
         case (cart_ram_size)
            8'd0:    last_lba = 8'd0;
            8'd1:    last_lba = 8'd3;
            8'd2:    last_lba = 8'd15;
            8'd3:    last_lba = 8'd63;
            default: last_lba = 8'd255;
         endcase
      end
   end

   assign load_rise = load_r & ~load_p;
   assign save_rise = save_r & ~save_p;
   assign auto_go   = osd_r & ~osd_p & autosave_en &
                      sav_pending & ~busy;
   assign accept    = (state == S_IDLE) && cart_ok &&
                      (load_rise || save_rise || auto_go);
   assign reject    = (state == S_IDLE) && !cart_ok &&
                      (load_rise || save_rise);
   assign ack_rise  = sd_ack & ~ack_q;
   assign ack_fall  = ~sd_ack & ack_q;
   assign at_last   = (lba == last_lba);

   // Request/ack edge history and the FSM state register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         load_r <= 1'b0;
         load_p <= 1'b0;
         save_r <= 1'b0;
         save_p <= 1'b0;
         osd_r  <= 1'b0;
         osd_p  <= 1'b0;
         ack_q  <= 1'b0;
         state  <= S_IDLE;
      end else begin
         load_r <= load_req;
         load_p <= load_r;
         save_r <= save_req;
         save_p <= save_r;
         osd_r  <= osd_open;
         osd_p  <= osd_r;
         ack_q  <= sd_ack;
         state  <= state_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d = state;
      busy    = 1'b0;
      done    = 1'b0;
      sd_rd   = 1'b0;
      sd_wr   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept)
               state_d = S_ISSUE;
            else if (reject)
               state_d = S_DONE;
         end
         S_ISSUE: begin
            busy  = 1'b1;
            sd_rd = loading;
            sd_wr = ~loading;
            if (ack_rise)
               state_d = S_XFER;
         end
         S_XFER: begin
            busy = 1'b1;
            if (ack_fall)
               state_d = S_NEXT;
         end
         S_NEXT: begin
            busy    = 1'b1;
            state_d = at_last ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Block counter, direction, error flag and dirty tracking.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         lba         <= 8'd0;
         loading     <= 1'b0;
         error       <= 1'b0;
         sav_pending <= 1'b0;
      end else begin
         if (accept) begin
            lba     <= 8'd0;
            loading <= load_rise;
            error   <= 1'b0;
         end else if (reject) begin
            error <= 1'b1;
         end else if (state == S_NEXT && !at_last) begin
            lba <= lba + 8'd1;
         end
         if (cart_ram_wr && cart_ok)
            sav_pending <= 1'b1;
         else if (accept)
            sav_pending <= 1'b0;
      end
   end

   assign sd_lba      = {24'd0, lba};
   assign bk_addr     = {lba, sd_buff_addr};
   assign bk_wr       = busy & loading & sd_ack & sd_buff_wr;
   assign bk_din      = is_mbc2 ? {4'hF, sd_buff_dout[3:0]}
                                : sd_buff_dout;
   assign sd_buff_din = bk_dout;

endmodule

// File: tb/tb_cart_ram_backup.sv
// tb_cart_ram_backup: randomized bench with an SD controller
// model, a cartridge RAM model and per-feature checks.
module tb_cart_ram_backup;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  cart_mbc_type = 8'h00;
   logic [7:0]  cart_ram_size = 8'h00;
   logic        load_req = 1'b0;
   logic        save_req = 1'b0;
   logic        autosave_en = 1'b0;
   logic        osd_open = 1'b0;
   logic        cart_ram_wr = 1'b0;
   logic        busy, done, error, sav_pending;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr;
   logic        sd_ack = 1'b0;
   logic [8:0]  sd_buff_addr = 9'd0;
   logic [7:0]  sd_buff_dout = 8'd0;
   logic        sd_buff_wr = 1'b0;
   logic [7:0]  sd_buff_din;
   logic [16:0] bk_addr;
   logic        bk_wr;
   logic [7:0]  bk_din;
   logic [7:0]  bk_dout = 8'd0;

   int n_chk = 0;
   int n_fail = 0;

   cart_ram_backup dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cart_mbc_type(cart_mbc_type),
      .cart_ram_size(cart_ram_size),
      .load_req(load_req), .save_req(save_req),
      .autosave_en(autosave_en), .osd_open(osd_open),
      .cart_ram_wr(cart_ram_wr),
      .busy(busy), .done(done), .error(error),
      .sav_pending(sav_pending), .sd_lba(sd_lba),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr),
      .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
      .bk_addr(bk_addr), .bk_wr(bk_wr), .bk_din(bk_din),
      .bk_dout(bk_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Cartridge RAM model with 1-cycle read latency.
   logic [7:0]  mem [0:131071];
   logic [7:0]  pre [0:131071];
   logic        pre_we = 1'b0;
   logic [16:0] pre_addr = 17'd0;
   logic [7:0]  pre_data = 8'd0;

   always @(posedge clk_sys) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bk_wr) mem[bk_addr] <= bk_din;
      bk_dout <= mem[bk_addr];
   end

   // Activity counters sampled mid-cycle.
   int done_cnt = 0;
   int rd_cyc = 0;
   int wr_cyc = 0;
   int bkwr_cyc = 0;

   always @(negedge clk_sys) begin
      if (done) done_cnt++;
      if (sd_rd) rd_cyc++;
      if (sd_wr) wr_cyc++;
      if (bk_wr) bkwr_cyc++;
   end

   // SD controller model state.
   logic [31:0] lba_q [$];
   logic [7:0]  cap_q [$];
   bit saw_rd, saw_wr, req_after_ack;
   int to_cnt = 0;

   task automatic preload(input int base, input int n);
      for (int k = 0; k < n; k++) begin
         pre_we   = 1'b1;
         pre_addr = 17'(base + k);
         pre_data = 8'($urandom);
         pre[base + k] = pre_data;
         @(negedge clk_sys);
      end
      pre_we = 1'b0;
   endtask

   // Serve block requests until done or max_blk blocks.
   task automatic serve(input logic ld,
                        input logic [7:0] seed,
                        input int max_blk);
      int w;
      int blocks;
      logic [7:0] cl;
      lba_q.delete();
      cap_q.delete();
      saw_rd = 0;
      saw_wr = 0;
      req_after_ack = 0;
      blocks = 0;
      while (blocks < max_blk) begin
         w = 0;
         while (!(sd_rd || sd_wr || done) && w < 300) begin
            @(negedge clk_sys);
            w++;
         end
         if (done) break;
         if (w >= 300) begin
            to_cnt++;
            break;
         end
         lba_q.push_back(sd_lba);
         cl = sd_lba[7:0];
         if (sd_rd) saw_rd = 1;
         if (sd_wr) saw_wr = 1;
         sd_ack = 1'b1;
         @(negedge clk_sys);
         if (sd_rd || sd_wr) req_after_ack = 1;
         for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'(i) ^ cl ^ seed;
            sd_buff_wr   = ld;
            @(negedge clk_sys);
            if (!ld) cap_q.push_back(sd_buff_din);
         end
         sd_buff_wr = 1'b0;
         sd_ack     = 1'b0;
         blocks++;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk_sys);
      n_chk++;
      if ({busy, done, error, sav_pending, sd_rd, sd_wr,
           bk_wr} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 0",
                  {busy, done, error, sav_pending,
                   sd_rd, sd_wr, bk_wr});
      end
      n_chk++;
      if (sd_lba !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_lba got %h want 0", sd_lba);
      end
      n_chk++;
      if (sd_buff_din !== bk_dout) begin
         n_fail++;
         $display("FAIL reset_buff_din got %h want %h",
                  sd_buff_din, bk_dout);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic test_load;
      logic [7:0] seed;
      int d0, bad;
      logic [7:0] e;
      seed = 8'($urandom);
      cart_mbc_type = 8'h03;
      cart_ram_size = 8'd2;
      @(negedge clk_sys);
      load_req = 1'b1;
      @(negedge clk_sys);
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL load_start_early got %b want 0", busy);
      end
      @(negedge clk_sys);
      n_chk++;
      if ({busy, sd_rd, sd_wr} !== 3'b110) begin
         n_fail++;
         $display("FAIL load_start got %b want 110",
                  {busy, sd_rd, sd_wr});
      end
      load_req = 1'b0;
      d0 = done_cnt;
      serve(1'b1, seed, 1000);
      repeat (2) @(negedge clk_sys);
      n_chk++;
      if (lba_q.size() != 16) begin
         n_fail++;
         $display("FAIL load_nblk got %0d want 16", lba_q.size());
      end
      bad = 0;
      foreach (lba_q[k]) if (lba_q[k] !== 32'(k)) bad++;
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL load_lba_seq got %0d bad want 0", bad);
      end
      n_chk++;
      if (done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL load_done got %0d want 1", done_cnt - d0);
      end
      n_chk++;
      if ({error, saw_wr, req_after_ack} !== 3'b000) begin
         n_fail++;
         $display("FAIL load_flags got %b want 000",
                  {error, saw_wr, req_after_ack});
      end
      bad = 0;
      for (int b = 0; b < 16; b++)
         for (int i = 0; i < 512; i++) begin
            e = 8'(i) ^ 8'(b) ^ seed;
            if (mem[b * 512 + i] !== e) bad++;
         end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL load_data got %0d bad want 0", bad);
      end
   endtask

   task automatic test_mbc2;
      int bk0, bad;
      logic [7:0] t;
      cart_mbc_type = 8'h06;
      cart_ram_size = 8'd0;
      preload(0, 1024);
      save_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      save_req = 1'b0;
      bk0 = bkwr_cyc;
      serve(1'b0, 8'd0, 1000);
      repeat (2) @(negedge clk_sys);
      n_chk++;
      if (lba_q.size() != 1 || lba_q[0] !== 32'd0) begin
         n_fail++;
         $display("FAIL mbc2_save_blk got %0d blocks want 1",
                  lba_q.size());
      end
      bad = 0;
      foreach (cap_q[i]) if (cap_q[i] !== pre[i]) bad++;
      n_chk++;
      if (bad != 0 || cap_q.size() != 512) begin
         n_fail++;
         $display("FAIL mbc2_save_data got %0d bad want 0", bad);
      end
      n_chk++;
      if (bkwr_cyc != bk0 || saw_rd) begin
         n_fail++;
         $display("FAIL mbc2_save_nowr got %0d want 0",
                  bkwr_cyc - bk0);
      end
      load_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      load_req = 1'b0;
      serve(1'b1, 8'h5A, 1000);
      repeat (2) @(negedge clk_sys);
      n_chk++;
      if (mem[0] !== 8'hFA) begin
         n_fail++;
         $display("FAIL mbc2_load_5a got %h want fa", mem[0]);
      end
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         t = 8'(i) ^ 8'h5A;
         if (mem[i] !== {4'hF, t[3:0]}) bad++;
      end
      n_chk++;
      if (bad != 0 || lba_q.size() != 1) begin
         n_fail++;
         $display("FAIL mbc2_load_data got %0d bad want 0", bad);
      end
      n_chk++;
      if (mem[512] !== pre[512]) begin
         n_fail++;
         $display("FAIL mbc2_load_blk1 got %h want %h",
                  mem[512], pre[512]);
      end
   endtask

   task automatic test_reject;
      int r0, w0;
      cart_mbc_type = 8'h01;
      cart_ram_size = 8'd2;
      @(negedge clk_sys);
      cart_ram_wr = 1'b1;
      @(negedge clk_sys);
      cart_ram_wr = 1'b0;
      n_chk++;
      if (sav_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL rej_pending got %b want 0", sav_pending);
      end
      r0 = rd_cyc;
      w0 = wr_cyc;
      save_req = 1'b1;
      @(negedge clk_sys);
      n_chk++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL rej_early got %b want 0", done);
      end
      @(negedge clk_sys);
      n_chk++;
      if ({done, error, busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL rej_pulse got %b want 110",
                  {done, error, busy});
      end
      @(negedge clk_sys);
      n_chk++;
      if ({done, error} !== 2'b01) begin
         n_fail++;
         $display("FAIL rej_hold got %b want 01", {done, error});
      end
      repeat (4) @(negedge clk_sys);
      save_req = 1'b0;
      n_chk++;
      if (rd_cyc != r0 || wr_cyc != w0) begin
         n_fail++;
         $display("FAIL rej_nosd got %0d want 0",
                  rd_cyc - r0 + wr_cyc - w0);
      end
      cart_mbc_type = 8'h03;
      cart_ram_size = 8'd0;
      cart_ram_wr = 1'b1;
      load_req = 1'b1;
      @(negedge clk_sys);
      cart_ram_wr = 1'b0;
      @(negedge clk_sys);
      n_chk++;
      if ({done, error, busy, sav_pending} !== 4'b1100) begin
         n_fail++;
         $display("FAIL rej_size got %b want 1100",
                  {done, error, busy, sav_pending});
      end
      load_req = 1'b0;
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic test_autosave;
      int bad, w0;
      cart_mbc_type = 8'h03;
      cart_ram_size = 8'd1;
      autosave_en = 1'b1;
      preload(0, 2048);
      cart_ram_wr = 1'b1;
      @(negedge clk_sys);
      cart_ram_wr = 1'b0;
      n_chk++;
      if ({sav_pending, error} !== 2'b11) begin
         n_fail++;
         $display("FAIL auto_pending got %b want 11",
                  {sav_pending, error});
      end
      osd_open = 1'b1;
      repeat (2) @(negedge clk_sys);
      n_chk++;
      if ({busy, sd_wr, sav_pending, error} !== 4'b1100) begin
         n_fail++;
         $display("FAIL auto_start got %b want 1100",
                  {busy, sd_wr, sav_pending, error});
      end
      osd_open = 1'b0;
      serve(1'b0, 8'd0, 1000);
      repeat (2) @(negedge clk_sys);
      bad = 0;
      foreach (lba_q[k]) if (lba_q[k] !== 32'(k)) bad++;
      foreach (cap_q[i]) if (cap_q[i] !== pre[i]) bad++;
      n_chk++;
      if (bad != 0 || cap_q.size() != 2048 || saw_rd) begin
         n_fail++;
         $display("FAIL auto_data got %0d bad %0d bytes want 0 2048",
                  bad, cap_q.size());
      end
      cart_ram_wr = 1'b1;
      @(negedge clk_sys);
      cart_ram_wr = 1'b0;
      osd_open = 1'b1;
      @(negedge clk_sys);
      cart_ram_wr = 1'b1;
      @(negedge clk_sys);
      cart_ram_wr = 1'b0;
      n_chk++;
      if ({busy, sav_pending} !== 2'b11) begin
         n_fail++;
         $display("FAIL auto_set_wins got %b want 11",
                  {busy, sav_pending});
      end
      osd_open = 1'b0;
      serve(1'b0, 8'd0, 1000);
      repeat (2) @(negedge clk_sys);
      autosave_en = 1'b0;
      w0 = wr_cyc;
      osd_open = 1'b1;
      repeat (5) @(negedge clk_sys);
      osd_open = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || wr_cyc != w0 || sav_pending !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_disabled got %b want 0", busy);
      end
   endtask

   task automatic test_both;
      int w0;
      cart_mbc_type = 8'h1B;
      cart_ram_size = 8'd1;
      w0 = wr_cyc;
      load_req = 1'b1;
      save_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      n_chk++;
      if ({sd_rd, sd_wr} !== 2'b10) begin
         n_fail++;
         $display("FAIL both_dir got %b want 10", {sd_rd, sd_wr});
      end
      save_req = 1'b0;
      @(negedge clk_sys);
      save_req = 1'b1;
      @(negedge clk_sys);
      load_req = 1'b0;
      serve(1'b1, 8'($urandom), 1000);
      repeat (6) @(negedge clk_sys);
      save_req = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || wr_cyc != w0 || saw_wr ||
          lba_q.size() != 4) begin
         n_fail++;
         $display("FAIL both_busy_save got %0d wr %0d blk want 0 4",
                  wr_cyc - w0, lba_q.size());
      end
   endtask

   task automatic test_reset_mid;
      int w, d0;
      cart_mbc_type = 8'h13;
      cart_ram_size = 8'd2;
      load_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      load_req = 1'b0;
      serve(1'b1, 8'($urandom), 1);
      w = 0;
      while (!sd_rd && w < 300) begin
         @(negedge clk_sys);
         w++;
      end
      n_chk++;
      if (w >= 300 || sd_lba !== 32'd1) begin
         n_fail++;
         $display("FAIL mid_lba got %0d want 1", sd_lba);
      end
      sd_ack = 1'b1;
      @(negedge clk_sys);
      sd_buff_wr = 1'b1;
      cart_ram_wr = 1'b1;
      @(negedge clk_sys);
      cart_ram_wr = 1'b0;
      n_chk++;
      if ({busy, sav_pending, bk_wr} !== 3'b111) begin
         n_fail++;
         $display("FAIL mid_state got %b want 111",
                  {busy, sav_pending, bk_wr});
      end
      d0 = done_cnt;
      #2 reset_n = 1'b0;
      #1;
      n_chk++;
      if ({busy, done, error, sav_pending, sd_rd, sd_wr,
           bk_wr} !== 7'b0 || sd_lba !== 32'd0) begin
         n_fail++;
         $display("FAIL mid_reset got %b lba %0d want 0",
                  {busy, done, error, sav_pending,
                   sd_rd, sd_wr, bk_wr}, sd_lba);
      end
      sd_ack = 1'b0;
      sd_buff_wr = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      load_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      load_req = 1'b0;
      serve(1'b1, 8'($urandom), 1000);
      repeat (2) @(negedge clk_sys);
      n_chk++;
      if (lba_q.size() != 16 || lba_q[0] !== 32'd0 ||
          done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL mid_restart got %0d blk %0d done want 16 1",
                  lba_q.size(), done_cnt - d0);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_mbc2();
      test_reject();
      test_autosave();
      test_both();
      test_reset_mid();
      n_chk++;
      if (to_cnt != 0) begin
         n_fail++;
         $display("FAIL timeouts got %0d want 0", to_cnt);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
